vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 sync block. It derives a pixel-rate tick from the system clock with an integer divider. It runs horizontal and vertical counters with porch and sync widths set by parameters, and drives sync pulses of selectable polarity, the active-video flag, pixel coordinates and line/frame boundary strobes. It sits between the system clock domain and the pixel/colour generators, which consume `p_tick`, `pixel_x`, `pixel_y` and `video_on`.

## Interface
- `H_DISPLAY`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync asserted level (0 = active-low)
- `V_POL`, 0, vsync asserted level (0 = active-low)
- `CLK_DIV`, 2, clk cycles per pixel (≥1)
- `CW`, 10, coordinate counter width
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  run enable; low freezes all state
- `p_tick`  out  1  pixel tick, one clk wide
- `hsync`  out  1  horizontal sync at `H_POL` level when asserted
- `vsync`  out  1  vertical sync at `V_POL` level when asserted
- `video_on`  out  1  inside the active region
- `pixel_x`  out  CW  horizontal count
- `pixel_y`  out  CW  vertical count
- `line_end`  out  1  strobe on the last tick of a line
- `frame_end`  out  1  strobe on the last tick of a frame

Clock `clk`; reset `reset`, synchronous, active-high. One clock domain only.

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL = the sum of the four vertical parameters. Elaboration fails if either total exceeds 2^CW, or if CLK_DIV < 1.
- Divider `div` counts 0..CLK_DIV-1 while `en`=1, wraps to 0, and holds while `en`=0. `p_tick = en & (div == CLK_DIV-1)`. For CLK_DIV=1, `p_tick = en`.
- Horizontal counter `h`: on `p_tick`, h = (h == H_TOTAL-1) ? 0 : h+1.
- Vertical counter `v`: on `p_tick & h==H_TOTAL-1`, v = (v == V_TOTAL-1) ? 0 : v+1.
- `pixel_x` = h and `pixel_y` = v, taken directly from the registers.
- `video_on = (h < H_DISPLAY) & (v < V_DISPLAY)`.
- hsync is asserted for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. Output level is `H_POL` when asserted, otherwise ~`H_POL`.
- vsync is asserted for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], with the same polarity rule using `V_POL`.
- `line_end = p_tick & (h == H_TOTAL-1)`. `frame_end = line_end & (v == V_TOTAL-1)`.
- All counter arithmetic is unsigned CW-bit. Comparisons use constants computed at elaboration.

## Timing
- Reset values: div=0, h=0, v=0, `p_tick`=0 (except CLK_DIV=1 with `en`=1), `hsync`=~H_POL, `vsync`=~V_POL, `video_on`=1, `pixel_x`=`pixel_y`=0, `line_end`=`frame_end`=0.
- Decoded outputs are combinational from the registers and have zero latency relative to `pixel_x`/`pixel_y`. They change on the clk edge after a `p_tick` cycle.
- First `p_tick` occurs CLK_DIV clks after reset deasserts, given `en`=1 throughout.
- `reset` takes priority over `en`. Reset mid-line or mid-frame returns to (0,0) on the next edge with no partial pulses.
- `en` low: all registers hold and strobes are 0. On re-enable, operation resumes from the exact held div/h/v.
- Wrap: h=H_TOTAL-1 and v=V_TOTAL-1 on a tick go to (0,0) on the same edge, with `line_end` and `frame_end` both high during that tick cycle.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: adds output `frame_count` [15:0]. It resets to 0, increments on each `frame_end`, wraps 65535→0, and holds when `en`=0.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package `vga_timing_pkg`: mode constants for 640x480@60 (the defaults), 800x600@60 and 1024x768@60, plus the polarity encodings.
- One sub-module, `vga_axis_counter`, instantiated twice (horizontal and vertical). It holds the mod-TOTAL counter with step enable, wrap flag, and display/sync-window decode.

## Test plan
- Defaults, CLK_DIV=2: hsync is 0 exactly for pixel_x 656..751, `video_on` drops at pixel_x=640, and `line_end` occurs every 1600 clks.
- Defaults: `frame_end` occurs every 840000 clks; vsync is 0 only for pixel_y 490..491; pixel_y wraps 524→0.
- H=4/1/1/2, V=3/1/1/1, CLK_DIV=1, H_POL=V_POL=1: h sequence is 0..7 repeating, hsync=1 only at h=5, vsync=1 only at v=4, frame length 48 clks.
- `en` dropped for 10 clks at (h=100, v=7, div=1): outputs frozen and strobes 0; after re-enable, the next tick advances to h=101.
- `reset` pulsed at h=700, v=300: next edge gives (0,0), hsync=1, vsync=1, first `p_tick` CLK_DIV clks later.
- With `VGA_TIMING_FRAME_CNT_EN`, preset via force to 65535: the next `frame_end` gives `frame_count`=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: standard modes and sync polarities.
// No logic; elaboration-time helpers only.
// Optional build macro VGA_TIMING_FRAME_CNT_EN is consumed by vga_timing_gen, not here.
package vga_timing_pkg;

  // Sync polarity encodings: the level driven while the pulse is asserted
  localparam bit POL_ACTIVE_LOW  = 1'b0;
  localparam bit POL_ACTIVE_HIGH = 1'b1;

  typedef enum logic [1:0] {
    MODE_640X480_60  = 2'd0,
    MODE_800X600_60  = 2'd1,
    MODE_1024X768_60 = 2'd2
  } vga_mode_e;

  // 640x480@60 (25.175 MHz nominal pixel clock) -- the generator defaults
  localparam int unsigned M640_H_DISPLAY = 640;
  localparam int unsigned M640_H_FRONT   = 16;
  localparam int unsigned M640_H_SYNC    = 96;
  localparam int unsigned M640_H_BACK    = 48;
  localparam int unsigned M640_V_DISPLAY = 480;
  localparam int unsigned M640_V_FRONT   = 10;
  localparam int unsigned M640_V_SYNC    = 2;
  localparam int unsigned M640_V_BACK    = 33;
  localparam bit          M640_H_POL     = POL_ACTIVE_LOW;
  localparam bit          M640_V_POL     = POL_ACTIVE_LOW;

  // 800x600@60 (40 MHz pixel clock)
  localparam int unsigned M800_H_DISPLAY = 800;
  localparam int unsigned M800_H_FRONT   = 40;
  localparam int unsigned M800_H_SYNC    = 128;
  localparam int unsigned M800_H_BACK    = 88;
  localparam int unsigned M800_V_DISPLAY = 600;
  localparam int unsigned M800_V_FRONT   = 1;
  localparam int unsigned M800_V_SYNC    = 4;
  localparam int unsigned M800_V_BACK    = 23;
  localparam bit          M800_H_POL     = POL_ACTIVE_HIGH;
  localparam bit          M800_V_POL     = POL_ACTIVE_HIGH;

  // 1024x768@60 (65 MHz pixel clock); horizontal total needs CW >= 11
  localparam int unsigned M1024_H_DISPLAY = 1024;
  localparam int unsigned M1024_H_FRONT   = 24;
  localparam int unsigned M1024_H_SYNC    = 136;
  localparam int unsigned M1024_H_BACK    = 160;
  localparam int unsigned M1024_V_DISPLAY = 768;
  localparam int unsigned M1024_V_FRONT   = 3;
  localparam int unsigned M1024_V_SYNC    = 6;
  localparam int unsigned M1024_V_BACK    = 29;
  localparam bit          M1024_H_POL     = POL_ACTIVE_LOW;
  localparam bit          M1024_V_POL     = POL_ACTIVE_LOW;

  // Period of one axis (pixels per line or lines per frame)
  function automatic int unsigned axis_total(input int unsigned display,
                                             input int unsigned front,
                                             input int unsigned sync,
                                             input int unsigned back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: mod-TOTAL counter with step enable, wrap flag and window decode.
// Latency: count advances on the edge after step; decodes are combinational from count.
// No backpressure: step is a single-cycle advance request, honoured every time.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned CW      = 10,
  parameter int unsigned DISPLAY = 640,
  parameter int unsigned FRONT   = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned BACK    = 48
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          active,
  output logic          in_sync
);

  localparam int unsigned TOTAL = axis_total(DISPLAY, FRONT, SYNC, BACK);

  // All window edges are fixed at elaboration so the decode is pure compares
  localparam logic [CW-1:0] LAST_C       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] DISPLAY_C    = CW'(DISPLAY);
  localparam logic [CW-1:0] SYNC_FIRST_C = CW'(DISPLAY + FRONT);
  localparam logic [CW-1:0] SYNC_LAST_C  = CW'(DISPLAY + FRONT + SYNC - 1);
  localparam bit            HAS_SYNC     = (SYNC != 0);

  logic [CW-1:0] count_q;

  // Advance on step, wrapping to zero after the last position of the period
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (step) begin
      count_q <= (count_q == LAST_C) ? '0 : count_q + 1'b1;
    end
  end

  // Window decode straight from the register so it lines up with count
  always_comb begin
    count   = count_q;
    last    = (count_q == LAST_C);
    active  = (count_q < DISPLAY_C);
    in_sync = HAS_SYNC && (count_q >= SYNC_FIRST_C) && (count_q <= SYNC_LAST_C);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: integer clk divider to pixel tick, h/v counters, sync/video/strobe decode.
// Latency: outputs are combinational from the counters and move on the edge after a p_tick cycle.
// No backpressure: en low freezes every register and forces strobes low. Macro VGA_TIMING_FRAME_CNT_EN adds frame_count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = M640_H_DISPLAY,
  parameter int unsigned H_FRONT   = M640_H_FRONT,
  parameter int unsigned H_SYNC    = M640_H_SYNC,
  parameter int unsigned H_BACK    = M640_H_BACK,
  parameter int unsigned V_DISPLAY = M640_V_DISPLAY,
  parameter int unsigned V_FRONT   = M640_V_FRONT,
  parameter int unsigned V_SYNC    = M640_V_SYNC,
  parameter int unsigned V_BACK    = M640_V_BACK,
  parameter bit          H_POL     = M640_H_POL,
  parameter bit          V_POL     = M640_V_POL,
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_end,
  output logic          frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_count
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  // Refuse configurations the counters cannot represent
  if (longint'(H_TOTAL) > (64'd1 << CW)) begin : g_h_total_too_wide
    $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
  end
  if (longint'(V_TOTAL) > (64'd1 << CW)) begin : g_v_total_too_wide
    $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  // A one-bit divider is kept for CLK_DIV=1; it then sits at zero forever
  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic          h_last;
  logic          v_last;
  logic          h_active;
  logic          v_active;
  logic          h_in_sync;
  logic          v_in_sync;

  // Pixel-rate divider: counts while enabled, holds its phase while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // Tick is gated by en so a frozen generator never advances or strobes
  always_comb begin
    p_tick    = en & (div_q == DIV_LAST);
    line_end  = p_tick & h_last;
    frame_end = line_end & v_last;
  end

  vga_axis_counter #(
    .CW      (CW),
    .DISPLAY (H_DISPLAY),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .reset   (reset),
    .step    (p_tick),
    .count   (h_count),
    .last    (h_last),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  // Vertical axis steps once per line, on the tick that wraps the horizontal axis
  vga_axis_counter #(
    .CW      (CW),
    .DISPLAY (V_DISPLAY),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .reset   (reset),
    .step    (line_end),
    .count   (v_count),
    .last    (v_last),
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  // Coordinates and video/sync levels, all zero-latency with respect to the counters
  always_comb begin
    pixel_x  = h_count;
    pixel_y  = v_count;
    video_on = h_active & v_active;
    hsync    = h_in_sync ? H_POL : ~H_POL;
    vsync    = v_in_sync ? V_POL : ~V_POL;
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter; frame_end already implies en, so it holds when disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_end) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule
